pipelined_cla_adder: RTL

Parametrised, pipelined carry-lookahead adder/subtractor. It generalises the team's fixed 4-bit and 8-bit lookahead adders to any WIDTH that is a multiple of GROUP. One GROUP-bit lookahead slice is resolved per pipeline stage, and the inter-group carry is registered between stages. A valid/ready handshake with global stall sits on both sides, so the block drops into the ALU datapath behind the operand register file.

---
 rtl/adder_pkg.sv | 21 ++
 rtl/pipelined_cla_adder_group.sv | 49 ++++
 rtl/pipelined_cla_adder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// Provides the op encoding for the sub input, stage-count derivation and a
// configuration legality check used at elaboration.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // One lookahead slice per pipeline stage.
  function automatic int unsigned calc_ngroups(input int unsigned width,
                                               input int unsigned group);
    return width / group;
  endfunction

  // WIDTH must be a non-zero multiple of GROUP.
  function automatic bit width_ok(input int unsigned width,
                                  input int unsigned group);
    return (group != 0) && (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_group.sv
// Combinational GROUP-bit carry-lookahead slice.
// Ports: a, b   - slice operands (b already conditioned for subtract)
//        cin    - carry into bit 0 of the slice
//        s      - slice sum
//        cout   - carry out of the slice MSB
//        cmsb   - carry into the slice MSB (for signed overflow)
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Sum-of-products form of c[i+1] = g[i] | p[i]&c[i], fully expanded so
  // every carry depends only on g, p and cin.
  always_comb begin
    logic prod;
    logic term;
    prod = 1'b1;
    term = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i <= int'(GROUP); i++) begin
      prod = 1'b1;
      term = 1'b0;
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i] = term | (prod & cin);
    end
  end

  assign s    = p ^ c[GROUP-1:0];
  assign cout = c[GROUP];
  assign cmsb = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one GROUP-bit slice per stage.
// Ports: clk, rst_n            - clock, async active-low reset
//        in_valid/in_ready     - operand handshake (in_ready = advance)
//        a, b, cin, sub        - operands; sub=1 computes a-b-cin
//        out_valid/out_ready   - result handshake
//        sum, cout, ovf, zero  - registered result and flags
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NGROUPS = calc_ngroups(WIDTH, GROUP);

  if (!width_ok(WIDTH, GROUP)) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  logic               advance;
  logic [WIDTH-1:0]   b_eff;
  logic               c0;

  // Stage registers; a_q/b_q carry the operand bits still to be summed.
  logic [NGROUPS-1:0] vld_q;
  logic [NGROUPS-1:0] c_q;
  logic [WIDTH-1:0]   a_q   [NGROUPS];
  logic [WIDTH-1:0]   b_q   [NGROUPS];
  logic [WIDTH-1:0]   s_q   [NGROUPS];
  logic               ovf_q;
  logic               zero_q;

  // Per-stage inputs (from the previous stage, or the ports for stage 0).
  logic [NGROUPS-1:0] vld_in;
  logic [NGROUPS-1:0] c_in;
  logic [WIDTH-1:0]   a_in  [NGROUPS];
  logic [WIDTH-1:0]   b_in  [NGROUPS];
  logic [WIDTH-1:0]   s_in  [NGROUPS];
  logic [WIDTH-1:0]   s_nxt [NGROUPS];
  logic [GROUP-1:0]   grp_s [NGROUPS];
  logic [NGROUPS-1:0] grp_c;
  logic               last_cmsb;

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign advance   = ~vld_q[NGROUPS-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[NGROUPS-1];
  assign sum       = s_q[NGROUPS-1];
  assign cout      = c_q[NGROUPS-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // A - B - cin == A + ~B + ~cin.
  assign b_eff = (sub == OP_SUB) ? ~b : b;
  assign c0    = (sub == OP_ADD) ? cin : ~cin;

  // Stage input selection.
  always_comb begin
    vld_in    = '0;
    c_in      = '0;
    vld_in[0] = in_valid;
    c_in[0]   = c0;
    a_in[0]   = a;
    b_in[0]   = b_eff;
    s_in[0]   = '0;
    for (int k = 1; k < int'(NGROUPS); k++) begin
      vld_in[k] = vld_q[k-1];
      c_in[k]   = c_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      s_in[k]   = s_q[k-1];
    end
  end

  // One lookahead slice per stage; only the last slice feeds ovf.
  for (genvar gi = 0; gi < int'(NGROUPS); gi++) begin : g_stage
    if (gi == int'(NGROUPS) - 1) begin : g_last
      cla_group #(.GROUP(GROUP)) u_cla (
        .a    (a_in[gi][gi*GROUP +: GROUP]),
        .b    (b_in[gi][gi*GROUP +: GROUP]),
        .cin  (c_in[gi]),
        .s    (grp_s[gi]),
        .cout (grp_c[gi]),
        .cmsb (last_cmsb)
      );
    end else begin : g_mid
      logic cmsb_unused;
      cla_group #(.GROUP(GROUP)) u_cla (
        .a    (a_in[gi][gi*GROUP +: GROUP]),
        .b    (b_in[gi][gi*GROUP +: GROUP]),
        .cin  (c_in[gi]),
        .s    (grp_s[gi]),
        .cout (grp_c[gi]),
        .cmsb (cmsb_unused)
      );
    end
  end

  // Merge each freshly computed slice into the travelling partial sum.
  always_comb begin
    for (int k = 0; k < int'(NGROUPS); k++) begin
      s_nxt[k] = s_in[k];
      s_nxt[k][k*GROUP +: GROUP] = grp_s[k];
    end
  end

  // Pipeline registers; data loads only with a valid beat so idle inputs
  // never disturb held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < int'(NGROUPS); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < int'(NGROUPS); k++) begin
        vld_q[k] <= vld_in[k];
        if (vld_in[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= s_nxt[k];
          c_q[k] <= grp_c[k];
        end
      end
      if (vld_in[NGROUPS-1]) begin
        ovf_q  <= last_cmsb ^ grp_c[NGROUPS-1];
        zero_q <= (s_nxt[NGROUPS-1] == '0);
      end
    end
  end

endmodule
